sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-ported synchronous SRAM between the pipeline's inst-fetch port and data port.
//  Sits between the core's inst_sram_*/data_sram_* and a unified sram instance.
//  Issues at most one access per cycle, returns read data one cycle later to the owner, and raises stallreq for the loser.
//  stallreq feeds the core stall input, stallreq_axi.
// PARAMETERS
//  ADDR_W    64  address width, byte address passed through unchanged
//  DATA_W    64  data width
//  STRB_W    8   byte-write-enable width, = DATA_W/8
//  MAX_WAIT  4   fixed-priority mode only: consecutive inst losses before inst is forced to win
// PORTS
//  clock          in   1       sole clock, rising edge
//  reset          in   1       synchronous, active-high
//  inst_en        in   1       inst read request; held stable by core until inst_gnt
//  inst_addr      in   ADDR_W  inst read address
//  inst_gnt       out  1       inst request issued to SRAM this cycle
//  inst_rvalid    out  1       inst_rdata valid; one cycle after inst_gnt
//  inst_rdata     out  DATA_W  inst read data
//  data_en        in   1       data request; held stable until data_gnt
//  data_we        in   STRB_W  byte enables; nonzero = write, zero = read
//  data_addr      in   ADDR_W  data address
//  data_wdata     in   DATA_W  write data
//  data_gnt       out  1       data request issued this cycle
//  data_rvalid    out  1       data_rdata valid; one cycle after a data read grant
//  data_rdata     out  DATA_W  data read data
//  stallreq       out  1       (inst_en & ~inst_gnt) | (data_en & ~data_gnt)
//  mem_en         out  1       SRAM enable
//  mem_we         out  STRB_W  SRAM byte write enables
//  mem_addr       out  ADDR_W  SRAM address
//  mem_wdata      out  DATA_W  SRAM write data
//  mem_rdata      in   DATA_W  SRAM read data, valid the cycle after mem_en with mem_we==0
// BEHAVIOUR
//  - Grant logic is combinational in the request cycle; throughput is 1 access/cycle with no bubble between grants.
//  - Only one request: it wins.
//  - Both requests: data wins by default (fixed priority), except when wait_cnt==MAX_WAIT, in which case inst wins.
//  - wait_cnt (clog2(MAX_WAIT+1) bits): +1 each cycle with inst_en & ~inst_gnt; saturates at MAX_WAIT; cleared on inst_gnt.
//  - mem_en = inst_gnt | data_gnt.
//  - mem_addr/mem_wdata/mem_we are muxed from the winner; inst access forces mem_we=0 and mem_wdata=0.
//  - When idle, mem_addr, mem_wdata and mem_we are 0.
//  - Response FSM resp_owner in {OWN_NONE, OWN_INST, OWN_DATA}, registered each cycle:
//      -> OWN_INST on inst_gnt
//      -> OWN_DATA on data_gnt & data_we==0
//      -> OWN_NONE otherwise (including data writes)
//  - inst_rvalid = (resp_owner==OWN_INST); data_rvalid = (resp_owner==OWN_DATA).
//  - inst_rdata and data_rdata both carry mem_rdata directly and are qualified only by their rvalid.
//  - A new grant in the same cycle as a response is legal; the response goes to the previous owner.
//  - Write followed by read of the same address on the next cycle returns the new data (SRAM write-first).
//  - Reset: resp_owner=OWN_NONE, wait_cnt=0, last_own=OWN_INST.
//  - Reset outputs: all gnt/rvalid/stallreq/mem_en = 0, mem_we = 0.
//  - Reset mid-operation drops any pending response; no rvalid in the cycle after reset.
//  - Requests sampled while reset is high are ignored.
//  - A requester that deasserts en before its grant is permitted; no state is retained for it.
// CONFIGURATION
//  SRAM_ARB_RR_EN defined:
//    - conflict winner = requester not in last_own; last_own updates on every grant
//    - wait_cnt logic and MAX_WAIT are unused
//  SRAM_ARB_RR_EN undefined:
//    - fixed data priority with MAX_WAIT starvation guard, as above
//    - last_own is held at reset value
// STRUCTURE
//  - OWN_NONE/OWN_INST/OWN_DATA (2b) encodings go in the shared defines file alongside the existing bus widths.
//  - One sub-module, arb2_pick: 2-input winner select (req_i[1:0], force_i, last_i) -> gnt_o[1:0].
//  - arb2_pick is purely combinational; all state stays in sram_port_arbiter.
// TESTING
//  1. inst_en=1 only, addr 0x80000000:
//     -> inst_gnt same cycle; next cycle inst_rvalid=1, inst_rdata=mem contents; stallreq=0.
//  2. data write we=0xFF, addr 0x80001000, wdata 0xDEADBEEF, then data read of the same address next cycle:
//     -> data_rvalid with 0xDEADBEEF; no inst_rvalid.
//  3. inst_en and data_en (read) held together 10 cycles, fixed mode:
//     -> data gnt 4 cycles, inst gnt on cycle 5, wait_cnt back to 0; stallreq=1 on every cycle with a loser.
//  4. Same as 3 with SRAM_ARB_RR_EN:
//     -> grants alternate data, inst, data, ...; each requester is served 5 times in 10 cycles.
//  5. Reset asserted the cycle after a data read grant:
//     -> data_rvalid=0 next cycle; all outputs 0; first grant occurs one cycle after reset deasserts.
//  6. Back-to-back inst reads A, B:
//     -> rvalid on consecutive cycles with data A then B; mem_en held 1 for two cycles.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: default bus widths and the
// response-owner encoding.
package sram_port_arbiter_pkg;

    localparam int unsigned AddrWDef   = 64;
    localparam int unsigned DataWDef   = 64;
    localparam int unsigned StrbWDef   = 8;
    localparam int unsigned MaxWaitDef = 4;

    // Owner of the read response returning in the next cycle
    typedef enum logic [1:0] {
        OwnNone = 2'b00,
        OwnInst = 2'b01,
        OwnData = 2'b10
    } own_e;

    // Next response owner given this cycle's grants; data writes return nothing
    function automatic own_e next_owner(logic inst_gnt, logic data_gnt, logic data_wr);
        if (inst_gnt) begin
            return OwnInst;
        end else if (data_gnt && !data_wr) begin
            return OwnData;
        end
        return OwnNone;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Core-side bus of the SRAM port arbiter: inst-fetch and data request ports
// plus the shared stall request. master = core pipeline, slave = arbiter.
interface sram_port_arbiter_if #(
    parameter int unsigned AddrW = 64,
    parameter int unsigned DataW = 64,
    parameter int unsigned StrbW = 8
) ();
    logic             inst_en;
    logic [AddrW-1:0] inst_addr;
    logic             inst_gnt;
    logic             inst_rvalid;
    logic [DataW-1:0] inst_rdata;

    logic             data_en;
    logic [StrbW-1:0] data_we;
    logic [AddrW-1:0] data_addr;
    logic [DataW-1:0] data_wdata;
    logic             data_gnt;
    logic             data_rvalid;
    logic [DataW-1:0] data_rdata;

    logic             stallreq;

    modport master (
        output inst_en, inst_addr,
        output data_en, data_we, data_addr, data_wdata,
        input  inst_gnt, inst_rvalid, inst_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  stallreq
    );

    modport slave (
        input  inst_en, inst_addr,
        input  data_en, data_we, data_addr, data_wdata,
        output inst_gnt, inst_rvalid, inst_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output stallreq
    );
endinterface

// File: rtl/sram_port_arbiter_arb2_pick.sv
// Two-input winner select. Bit 0 = inst, bit 1 = data. On conflict data wins
// unless force_i (starvation guard) or last_i (data owned last, round-robin).
module sram_port_arbiter_arb2_pick (
    input  logic [1:0] req_i,
    input  logic       force_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Single requester always wins; conflict resolved by force/last
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (force_i || last_i) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between inst-fetch and data ports.
// Grants are combinational; read data returns one cycle later to its owner.
// Build option: define SRAM_ARB_RR_EN for round-robin conflict resolution;
// otherwise data has fixed priority with a MaxWait inst starvation guard.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned AddrW   = AddrWDef,
    parameter int unsigned DataW   = DataWDef,
    parameter int unsigned StrbW   = StrbWDef,
    parameter int unsigned MaxWait = MaxWaitDef
) (
    input  logic             clock,
    input  logic             reset,
    sram_port_arbiter_if.slave core_io,
    output logic             mem_en_o,
    output logic [StrbW-1:0] mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    input  logic [DataW-1:0] mem_rdata_i
);

    own_e       resp_owner_q, resp_owner_d;
    own_e       last_own_q, last_own_d;
    logic [1:0] req;
    logic [1:0] pick;
    logic       force_inst;
    logic       inst_gnt;
    logic       data_gnt;

`ifdef SRAM_ARB_RR_EN
    assign force_inst = 1'b0;
`else
    localparam int unsigned WaitW = $clog2(MaxWait + 1);

    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

    assign force_inst = (wait_cnt_q == WaitW'(MaxWait));

    // Count consecutive inst losses, saturating; cleared when inst is served
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (inst_gnt) begin
            wait_cnt_d = '0;
        end else if (core_io.inst_en && (wait_cnt_q != WaitW'(MaxWait))) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign req = {core_io.data_en, core_io.inst_en};

    sram_port_arbiter_arb2_pick u_pick (
        .req_i   (req),
        .force_i (force_inst),
        .last_i  (last_own_q == OwnData),
        .gnt_o   (pick)
    );

    // Requests seen while reset is high are never granted
    assign inst_gnt = pick[0] & ~reset;
    assign data_gnt = pick[1] & ~reset;

    // State register: response owner and last grant owner
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_owner_q <= OwnNone;
            last_own_q   <= OwnInst;
        end else begin
            resp_owner_q <= resp_owner_d;
            last_own_q   <= last_own_d;
        end
    end

    // Next state: response goes to whoever issued a read this cycle
    always_comb begin
        resp_owner_d = next_owner(inst_gnt, data_gnt, core_io.data_we != '0);
        last_own_d   = last_own_q;
`ifdef SRAM_ARB_RR_EN
        if (inst_gnt) begin
            last_own_d = OwnInst;
        end else if (data_gnt) begin
            last_own_d = OwnData;
        end
`endif
    end

    // Outputs: grants, SRAM mux (zero when idle), response valids, stall
    always_comb begin
        core_io.inst_gnt    = inst_gnt;
        core_io.data_gnt    = data_gnt;
        core_io.inst_rvalid = (resp_owner_q == OwnInst) & ~reset;
        core_io.data_rvalid = (resp_owner_q == OwnData) & ~reset;
        core_io.inst_rdata  = mem_rdata_i;
        core_io.data_rdata  = mem_rdata_i;
        core_io.stallreq    = ~reset & ((core_io.inst_en & ~inst_gnt) |
                                        (core_io.data_en & ~data_gnt));

        mem_en_o    = inst_gnt | data_gnt;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (inst_gnt) begin
            mem_addr_o = core_io.inst_addr;
        end else if (data_gnt) begin
            mem_we_o    = core_io.data_we;
            mem_addr_o  = core_io.data_addr;
            mem_wdata_o = core_io.data_wdata;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a write-first SRAM model and a
// scoreboard of expected read responses per port.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [7:0]  mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int unsigned checks;
    int unsigned errors;

    logic [63:0] inst_exp_q[$];
    logic [63:0] data_exp_q[$];
    logic [63:0] sram[logic [63:0]];
    logic [63:0] ref_mem[logic [63:0]];

    sram_port_arbiter_if bus ();

    sram_port_arbiter dut (
        .clock       (clk),
        .reset       (rst),
        .core_io     (bus.slave),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_pat(logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_5A5A, a[31:0]};
    endfunction

    // Synchronous write-first SRAM
    always @(posedge clk) begin
        if (mem_en) begin
            logic [63:0] cur;
            cur = sram.exists(mem_addr) ? sram[mem_addr] : init_pat(mem_addr);
            if (mem_we != 8'h00) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_we[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                sram[mem_addr] = cur;
            end
            mem_rdata <= cur;
        end
    end

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [63:0] ref_rd(logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    endfunction

    function automatic void ref_write(logic [63:0] a, logic [7:0] we, logic [63:0] wd);
        logic [63:0] cur;
        cur = ref_rd(a);
        for (int b = 0; b < 8; b++) begin
            if (we[b]) cur[8*b +: 8] = wd[8*b +: 8];
        end
        ref_mem[a] = cur;
    endfunction

    // Scoreboard monitor: every rvalid must match the oldest expected response
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.inst_rvalid === 1'b1) begin
            if (inst_exp_q.size() == 0) begin
                check("inst_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = inst_exp_q.pop_front();
                check("inst_rdata", bus.inst_rdata, e);
            end
        end
        if (bus.data_rvalid === 1'b1) begin
            if (data_exp_q.size() == 0) begin
                check("data_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = data_exp_q.pop_front();
                check("data_rdata", bus.data_rdata, e);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic ie, input logic [63:0] ia, input logic de,
                           input logic [7:0] dwe, input logic [63:0] da,
                           input logic [63:0] dwd);
        bus.inst_en    = ie;
        bus.inst_addr  = ia;
        bus.data_en    = de;
        bus.data_we    = dwe;
        bus.data_addr  = da;
        bus.data_wdata = dwd;
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_inst_gnt"}, 64'(bus.inst_gnt), 64'd0);
        check({tag, "_data_gnt"}, 64'(bus.data_gnt), 64'd0);
        check({tag, "_stallreq"}, 64'(bus.stallreq), 64'd0);
        check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_inst_rvalid"}, 64'(bus.inst_rvalid), 64'd0);
        check({tag, "_data_rvalid"}, 64'(bus.data_rvalid), 64'd0);
    endtask

    function automatic bit inst_wins(int i);
`ifdef SRAM_ARB_RR_EN
        return (i % 2) == 1;
`else
        return (i % 5) == 4;
`endif
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_req(1'b0, '0, 1'b0, '0, '0, '0);

        // Reset with both requests asserted: everything must stay quiet
        repeat (2) begin
            next_cycle();
            set_req(1'b1, 64'h8000_0000, 1'b1, 8'h00, 64'h8000_1000, '0);
            @(negedge clk);
            check_quiet("reset");
        end

        // First idle cycle after reset: no stale response, SRAM bus zeroed
        next_cycle();
        rst = 1'b0;
        set_req(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check_quiet("idle");
        check("idle_mem_addr", mem_addr, 64'd0);
        check("idle_mem_wdata", mem_wdata, 64'd0);

        // 1. Lone inst read
        next_cycle();
        set_req(1'b1, 64'h8000_0000, 1'b0, '0, '0, '0);
        inst_exp_q.push_back(ref_rd(64'h8000_0000));
        @(negedge clk);
        check("t1_inst_gnt", 64'(bus.inst_gnt), 64'd1);
        check("t1_stallreq", 64'(bus.stallreq), 64'd0);
        check("t1_mem_en", 64'(mem_en), 64'd1);
        check("t1_mem_addr", mem_addr, 64'h8000_0000);
        check("t1_mem_we", 64'(mem_we), 64'd0);
        next_cycle();
        set_req(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("t1_rvalid", 64'(bus.inst_rvalid), 64'd1);

        // 2. Full write then read of same address
        next_cycle();
        set_req(1'b0, '0, 1'b1, 8'hFF, 64'h8000_1000, 64'h0000_0000_DEAD_BEEF);
        ref_write(64'h8000_1000, 8'hFF, 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        check("t2_wr_gnt", 64'(bus.data_gnt), 64'd1);
        check("t2_mem_we", 64'(mem_we), 64'hFF);
        check("t2_mem_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
        check("t2_mem_addr", mem_addr, 64'h8000_1000);
        next_cycle();
        set_req(1'b0, '0, 1'b1, 8'h00, 64'h8000_1000, '0);
        data_exp_q.push_back(64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        check("t2_no_rvalid_after_write", 64'(bus.data_rvalid), 64'd0);
        check("t2_rd_gnt", 64'(bus.data_gnt), 64'd1);
        check("t2_rd_mem_we", 64'(mem_we), 64'd0);

        // Partial-strobe write then read back the merged word
        next_cycle();
        set_req(1'b0, '0, 1'b1, 8'h0F, 64'h8000_1000, 64'h1111_2222_3333_4444);
        ref_write(64'h8000_1000, 8'h0F, 64'h1111_2222_3333_4444);
        @(negedge clk);
        check("t2_rd_rvalid", 64'(bus.data_rvalid), 64'd1);
        next_cycle();
        set_req(1'b0, '0, 1'b1, 8'h00, 64'h8000_1000, '0);
        data_exp_q.push_back(64'h0000_0000_3333_4444);
        @(negedge clk);
        check("t2_partial_no_rvalid", 64'(bus.data_rvalid), 64'd0);
        next_cycle();
        set_req(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);

        // Reset to restart arbitration state before the conflict run
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        next_cycle();
        rst = 1'b0;

        // 3/4. Both requesting for 10 cycles
        begin
            int n_inst = 0;
            int n_data = 0;
            for (int i = 0; i < 10; i++) begin
                if (i != 0) next_cycle();
                set_req(1'b1, 64'h8000_0100, 1'b1, 8'h00, 64'h8000_2000, '0);
                if (inst_wins(i)) inst_exp_q.push_back(ref_rd(64'h8000_0100));
                else              data_exp_q.push_back(ref_rd(64'h8000_2000));
                @(negedge clk);
                check($sformatf("t3_inst_gnt_%0d", i), 64'(bus.inst_gnt), 64'(inst_wins(i)));
                check($sformatf("t3_data_gnt_%0d", i), 64'(bus.data_gnt), 64'(!inst_wins(i)));
                check($sformatf("t3_stallreq_%0d", i), 64'(bus.stallreq), 64'd1);
                if (bus.inst_gnt === 1'b1) n_inst++;
                if (bus.data_gnt === 1'b1) n_data++;
            end
`ifdef SRAM_ARB_RR_EN
            check("t4_inst_served", 64'(n_inst), 64'd5);
            check("t4_data_served", 64'(n_data), 64'd5);
`else
            check("t3_inst_served", 64'(n_inst), 64'd2);
            check("t3_data_served", 64'(n_data), 64'd8);
`endif
        end
        next_cycle();
        set_req(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("t3_idle_stallreq", 64'(bus.stallreq), 64'd0);

        // 5. Reset the cycle after a data read grant drops the response
        next_cycle();
        set_req(1'b0, '0, 1'b1, 8'h00, 64'h8000_3000, '0);
        @(negedge clk);
        check("t5_data_gnt", 64'(bus.data_gnt), 64'd1);
        next_cycle();
        rst = 1'b1;
        set_req(1'b1, 64'h8000_0200, 1'b0, '0, '0, '0);
        @(negedge clk);
        check_quiet("t5_reset");
        next_cycle();
        rst = 1'b0;
        inst_exp_q.push_back(ref_rd(64'h8000_0200));
        @(negedge clk);
        check("t5_first_gnt", 64'(bus.inst_gnt), 64'd1);
        check("t5_data_rvalid", 64'(bus.data_rvalid), 64'd0);

        // 6. Back-to-back inst reads A then B
        next_cycle();
        set_req(1'b1, 64'h8000_0300, 1'b0, '0, '0, '0);
        inst_exp_q.push_back(ref_rd(64'h8000_0300));
        @(negedge clk);
        check("t6_mem_en_a", 64'(mem_en), 64'd1);
        next_cycle();
        set_req(1'b1, 64'h8000_0308, 1'b0, '0, '0, '0);
        inst_exp_q.push_back(ref_rd(64'h8000_0308));
        @(negedge clk);
        check("t6_mem_en_b", 64'(mem_en), 64'd1);
        check("t6_mem_addr_b", mem_addr, 64'h8000_0308);
        check("t6_rvalid_a", 64'(bus.inst_rvalid), 64'd1);
        next_cycle();
        set_req(1'b0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("t6_rvalid_b", 64'(bus.inst_rvalid), 64'd1);
        check("t6_mem_en_off", 64'(mem_en), 64'd0);

        repeat (2) begin
            next_cycle();
            @(negedge clk);
        end
        check("inst_responses_outstanding", 64'(inst_exp_q.size()), 64'd0);
        check("data_responses_outstanding", 64'(data_exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
